// File: rtl/psx_state_arbiter.sv
// ---------------------------------------------------------------------------
// psx_state_arbiter
//   Round-robin arbiter that shares the PSX controller state-RAM write port
//   between requester A (host link) and requester B (local scanner). A grant
//   is only issued while no PSX packet is in progress, so a poll reply never
//   observes a half-written frame start. Once granted, a burst of len bytes
//   is written at consecutive (wrapping) addresses and always runs to the end.
//
// Ports
//   clk_i          system clock
//   reset_i        synchronous, active-high reset
//   a_req_i        A burst request, held until a_done_o
//   a_addr_i       A start address, sampled at grant
//   a_len_i        A byte count, sampled at grant (0 = empty burst)
//   a_data_i       A byte stream data
//   a_valid_i      A byte stream valid
//   a_ready_o      A byte accepted this cycle (combinational)
//   a_done_o       one-cycle pulse when the A burst completes
//   b_*            same set for requester B
//   port_busy_i    high while a PSX packet is active; blocks new grants
//   write_addr_o   state RAM write address
//   write_data_o   state RAM write data
//   write_en_o     state RAM write enable (one cycle after each handshake)
//   active_o       high while a burst is in BURST or FINISH
//   owner_o        0 = A, 1 = B; meaningful while active_o is high
// ---------------------------------------------------------------------------
module psx_state_arbiter #(
  parameter int unsigned ADDR_BITS = 5,
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,

  input  logic                 a_req_i,
  input  logic [ADDR_BITS-1:0] a_addr_i,
  input  logic [ADDR_BITS-1:0] a_len_i,
  input  logic [DATA_BITS-1:0] a_data_i,
  input  logic                 a_valid_i,
  output logic                 a_ready_o,
  output logic                 a_done_o,

  input  logic                 b_req_i,
  input  logic [ADDR_BITS-1:0] b_addr_i,
  input  logic [ADDR_BITS-1:0] b_len_i,
  input  logic [DATA_BITS-1:0] b_data_i,
  input  logic                 b_valid_i,
  output logic                 b_ready_o,
  output logic                 b_done_o,

  input  logic                 port_busy_i,

  output logic [ADDR_BITS-1:0] write_addr_o,
  output logic [DATA_BITS-1:0] write_data_o,
  output logic                 write_en_o,
  output logic                 active_o,
  output logic                 owner_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BURST  = 2'd1,
    S_FINISH = 2'd2
  } state_e;

  localparam logic OWNER_A = 1'b0;
  localparam logic OWNER_B = 1'b1;

  // State and datapath registers
  state_e               state_q,      state_d;
  logic                 owner_q,      owner_d;
  logic                 last_owner_q, last_owner_d;
  logic [ADDR_BITS-1:0] addr_q,       addr_d;
  logic [ADDR_BITS-1:0] cnt_q,        cnt_d;
  logic [ADDR_BITS-1:0] len_q,        len_d;

  // Registered outputs
  logic                 write_en_q,   write_en_d;
  logic [ADDR_BITS-1:0] write_addr_q, write_addr_d;
  logic [DATA_BITS-1:0] write_data_q, write_data_d;
  logic                 a_done_q,     a_done_d;
  logic                 b_done_q,     b_done_d;
  logic                 active_q,     active_d;

  // Grant and handshake helpers
  logic                 winner;
  logic [ADDR_BITS-1:0] grant_addr;
  logic [ADDR_BITS-1:0] grant_len;
  logic                 own_valid;
  logic [DATA_BITS-1:0] own_data;
  logic                 in_burst;
  logic                 handshake;

  // Owner-side byte stream; the non-owner stream is never looked at
  assign in_burst  = (state_q == S_BURST);
  assign own_valid = (owner_q == OWNER_B) ? b_valid_i : a_valid_i;
  assign own_data  = (owner_q == OWNER_B) ? b_data_i  : a_data_i;
  assign handshake = in_burst && own_valid;

  // Ready is a pure decode of state/owner so the requester sees it in the same cycle
  assign a_ready_o = in_burst && (owner_q == OWNER_A);
  assign b_ready_o = in_burst && (owner_q == OWNER_B);

  assign write_en_o   = write_en_q;
  assign write_addr_o = write_addr_q;
  assign write_data_o = write_data_q;
  assign a_done_o     = a_done_q;
  assign b_done_o     = b_done_q;
  assign active_o     = active_q;
  assign owner_o      = owner_q;

  // Round-robin winner: a lone requester wins, a tie goes away from last_owner
  always_comb begin
    winner     = OWNER_A;
    grant_addr = a_addr_i;
    grant_len  = a_len_i;
    if (a_req_i && b_req_i) begin
      winner = ~last_owner_q;
    end else if (b_req_i) begin
      winner = OWNER_B;
    end
    if (winner == OWNER_B) begin
      grant_addr = b_addr_i;
      grant_len  = b_len_i;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    len_d        = len_q;
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;

    unique case (state_q)
      S_IDLE: begin
        if (!port_busy_i && (a_req_i || b_req_i)) begin
          owner_d = winner;
          addr_d  = grant_addr;
          len_d   = grant_len;
          cnt_d   = '0;
          state_d = (grant_len == '0) ? S_FINISH : S_BURST;
        end
      end

      S_BURST: begin
        // port_busy and req are deliberately ignored here: bursts never abort
        if (handshake) begin
          write_en_d   = 1'b1;
          write_addr_d = addr_q;
          write_data_d = own_data;
          addr_d       = addr_q + ADDR_BITS'(1);
          cnt_d        = cnt_q + ADDR_BITS'(1);
          if (cnt_q == len_q - ADDR_BITS'(1)) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        last_owner_d = owner_q;
        state_d      = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Done and active are registered from the next state so they line up with FINISH
    a_done_d = (state_d == S_FINISH) && (owner_d == OWNER_A);
    b_done_d = (state_d == S_FINISH) && (owner_d == OWNER_B);
    active_d = (state_d != S_IDLE);
  end

  // State register; last_owner resets to B so A wins the first tie
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      owner_q      <= OWNER_A;
      last_owner_q <= OWNER_B;
      addr_q       <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      write_en_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      a_done_q     <= 1'b0;
      b_done_q     <= 1'b0;
      active_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
      a_done_q     <= a_done_d;
      b_done_q     <= b_done_d;
      active_q     <= active_d;
    end
  end

endmodule
